// File: rtl/trdb_pkg.sv
// Shared trace-debug types: packet formats, scheduler states and the queued request record.
package trdb_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned KEEP_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    F_BRANCH_FULL = 2'h0,
    F_BRANCH_DIFF = 2'h1,
    F_ADDR_ONLY   = 2'h2,
    F_SYNC        = 2'h3
  } trdb_format_t;

  typedef enum logic [1:0] {
    SF_START     = 2'h0,
    SF_EXCEPTION = 2'h1,
    SF_CONTEXT   = 2'h2,
    SF_RESERVED  = 2'h3
  } trdb_subformat_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'h0,
    S_RUN   = 2'h1,
    S_DRAIN = 2'h2
  } trdb_sched_state_e;

  typedef struct packed {
    trdb_format_t    format;
    trdb_subformat_t subformat;
    logic [KEEP_W-1:0] keep_bits;
    logic [XLEN-1:0]   addr;
  } trdb_pkt_req_t;
endpackage

// File: rtl/trdb_fifo.sv
// Generic register FIFO; head entry is presented straight from the storage flops.
module trdb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type T = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     data_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  T              mem_q [DEPTH];
  T              mem_d [DEPTH];

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/trdb_packet_sched.sv
// Packet scheduler: queues requests for the emitter, tracks periodic/overflow resync
// and sequences enable/disable with a drain phase.
module trdb_packet_sched
  import trdb_pkg::*;
#(
  parameter int unsigned XLEN     = trdb_pkg::XLEN,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESYNC_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [RESYNC_W-1:0]    resync_max_i,
  input  logic                   req_valid_i,
  input  trdb_format_t           req_format_i,
  input  trdb_subformat_t        req_subformat_i,
  input  logic [$clog2(XLEN):0]  req_keep_bits_i,
  input  logic [XLEN-1:0]        req_addr_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output trdb_format_t           out_format_o,
  output trdb_subformat_t        out_subformat_o,
  output logic [$clog2(XLEN):0]  out_keep_bits_o,
  output logic [XLEN-1:0]        out_addr_o,
  output logic                   resync_pending_o,
  output logic                   overflow_o,
  output logic [RESYNC_W-1:0]    drop_cnt_o,
  output logic                   idle_o
);
  trdb_sched_state_e   state_q, state_d;
  logic [RESYNC_W-1:0] cnt_q, cnt_d, drop_cnt_q, drop_cnt_d;
  logic                pending_q, pending_d, overflow_q, overflow_d, reached_q, reached_d;
  logic                fifo_full, fifo_empty, push_req, push, pop, drop, at_max, run_entry;
  trdb_pkt_req_t       req_pkt, head_pkt;

  assign req_pkt  = '{format: req_format_i, subformat: req_subformat_i,
                      keep_bits: req_keep_bits_i, addr: req_addr_i};
  assign push_req = (state_q == S_RUN) && enable_i && req_valid_i;
  assign pop      = !fifo_empty && out_ready_i;
  assign drop     = push_req && fifo_full && !pop;
  assign push     = push_req && !drop;
  assign at_max   = (resync_max_i != '0) && (cnt_q == resync_max_i);

  trdb_fifo #(.DEPTH(DEPTH), .T(trdb_pkt_req_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (req_pkt),
    .data_o  (head_pkt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    reached_d  = at_max;
    pending_d  = pending_q;
    run_entry  = 1'b0;

    unique case (state_q)
      S_IDLE:  if (enable_i) begin state_d = S_RUN; run_entry = 1'b1; end
      S_RUN:   if (!enable_i) state_d = S_DRAIN;
      S_DRAIN: if (enable_i) state_d = S_RUN;
               else if (fifo_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      if (head_pkt.format == F_SYNC) cnt_d = '0;
      else if (!at_max)              cnt_d = cnt_q + RESYNC_W'(1);
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + RESYNC_W'(1);
    end

    // Periodic set fires once on reaching the limit, so a queued sync can clear it.
    if (drop || (at_max && !reached_q))            pending_d = 1'b1;
    else if (push && (req_format_i == F_SYNC))     pending_d = 1'b0;

    if (run_entry) begin
      cnt_d      = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
      reached_d  = 1'b0;
    end
    if (state_d == S_IDLE) pending_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      reached_q  <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      reached_q  <= reached_d;
      pending_q  <= pending_d;
    end
  end

  assign out_valid_o      = !fifo_empty;
  assign out_format_o     = head_pkt.format;
  assign out_subformat_o  = head_pkt.subformat;
  assign out_keep_bits_o  = head_pkt.keep_bits;
  assign out_addr_o       = head_pkt.addr;
  assign resync_pending_o = pending_q;
  assign overflow_o       = overflow_q;
  assign drop_cnt_o       = drop_cnt_q;
  assign idle_o           = (state_q == S_IDLE);
endmodule

// File: tb/tb_trdb_packet_sched.sv
// Directed bench for trdb_packet_sched with a scoreboard of expected emitter packets.
module tb_trdb_packet_sched;
  import trdb_pkg::*;

  localparam int unsigned RW = 16;

  logic            clk = 1'b0;
  logic            rst, enable, req_valid, out_valid, out_ready, pending, overflow, idle;
  logic [RW-1:0]   resync_max, drop_cnt;
  trdb_format_t    req_format, out_format;
  trdb_subformat_t req_sub, out_sub;
  logic [5:0]      req_keep, out_keep;
  logic [31:0]     req_addr, out_addr;

  typedef struct {
    trdb_format_t fmt;
    logic [31:0]  addr;
    logic [5:0]   keep;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;

  trdb_packet_sched dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .enable_i         (enable),
    .resync_max_i     (resync_max),
    .req_valid_i      (req_valid),
    .req_format_i     (req_format),
    .req_subformat_i  (req_sub),
    .req_keep_bits_i  (req_keep),
    .req_addr_i       (req_addr),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_format_o     (out_format),
    .out_subformat_o  (out_sub),
    .out_keep_bits_o  (out_keep),
    .out_addr_o       (out_addr),
    .resync_pending_o (pending),
    .overflow_o       (overflow),
    .drop_cnt_o       (drop_cnt),
    .idle_o           (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for one cycle; accepted ones are expected at the emitter in order.
  task automatic drive_req(input trdb_format_t f, input logic [31:0] a, input bit accept);
    logic [5:0] k;
    k          = 6'(a[4:0]) + 6'd1;
    req_valid  = 1'b1;
    req_format = f;
    req_sub    = SF_START;
    req_keep   = k;
    req_addr   = a;
    if (accept) sb.push_back('{fmt: f, addr: a, keep: k, cyc: cyc});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Emitter side: every accepted head is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("pop_with_empty_scoreboard", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("pop  cyc=%0d fmt=%0d addr=0x%08h keep=%0d", cyc, out_format, out_addr, out_keep);
        chk("pop_format", 64'(out_format), 64'(mon_e.fmt));
        chk("pop_addr", 64'(out_addr), 64'(mon_e.addr));
        chk("pop_keep", 64'(out_keep), 64'(mon_e.keep));
        if (chk_lat) chk("pop_latency", 64'(cyc), 64'(mon_e.cyc + 1));
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; resync_max = '0; req_valid = 1'b0;
    req_format = F_BRANCH_FULL; req_sub = SF_START; req_keep = '0; req_addr = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_idle", 64'(idle), 64'd1);
    chk("reset_pending", 64'(pending), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // 1: three pushes streamed straight through
    enable = 1'b1; out_ready = 1'b1;
    tick();
    chk("run_not_idle", 64'(idle), 64'd0);
    chk_lat = 1'b1;
    drive_req(F_BRANCH_FULL, 32'h100, 1'b1);
    drive_req(F_BRANCH_FULL, 32'h104, 1'b1);
    drive_req(F_BRANCH_FULL, 32'h108, 1'b1);
    wait_empty("t1_drain");
    chk_lat = 1'b0;

    // 2: overflow with emitter stalled
    out_ready = 1'b0;
    drive_req(F_BRANCH_DIFF, 32'h200, 1'b1);
    drive_req(F_BRANCH_DIFF, 32'h204, 1'b1);
    drive_req(F_BRANCH_DIFF, 32'h208, 1'b1);
    drive_req(F_BRANCH_DIFF, 32'h20C, 1'b1);
    drive_req(F_BRANCH_DIFF, 32'h210, 1'b0);
    chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_pending", 64'(pending), 64'd1);
    chk("t2_head_addr", 64'(out_addr), 64'h200);
    out_ready = 1'b1;
    wait_empty("t2_drain");

    // 3: periodic resync
    resync_max = 16'd3;
    drive_req(F_SYNC, 32'h300, 1'b1);
    wait_empty("t3_sync0");
    tick();
    chk("t3_pending_cleared", 64'(pending), 64'd0);
    drive_req(F_BRANCH_FULL, 32'h310, 1'b1);
    drive_req(F_BRANCH_FULL, 32'h314, 1'b1);
    drive_req(F_BRANCH_FULL, 32'h318, 1'b1);
    wait_empty("t3_three");
    repeat (2) tick();
    chk("t3_resync_set", 64'(pending), 64'd1);
    drive_req(F_SYNC, 32'h31C, 1'b1);
    chk("t3_clear_on_sync_push", 64'(pending), 64'd0);
    wait_empty("t3_sync1");
    drive_req(F_BRANCH_FULL, 32'h320, 1'b1);
    drive_req(F_BRANCH_FULL, 32'h324, 1'b1);
    wait_empty("t3_two");
    repeat (2) tick();
    chk("t3_counter_restarted", 64'(pending), 64'd0);
    drive_req(F_BRANCH_FULL, 32'h328, 1'b1);
    wait_empty("t3_third");
    repeat (2) tick();
    chk("t3_resync_again", 64'(pending), 64'd1);
    drive_req(F_SYNC, 32'h32C, 1'b1);
    wait_empty("t3_sync2");
    resync_max = '0;
    tick();

    // 4: full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    drive_req(F_ADDR_ONLY, 32'h400, 1'b1);
    drive_req(F_ADDR_ONLY, 32'h404, 1'b1);
    drive_req(F_ADDR_ONLY, 32'h408, 1'b1);
    drive_req(F_ADDR_ONLY, 32'h40C, 1'b1);
    repeat (2) tick();
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_hold_addr", 64'(out_addr), 64'h400);
    chk("t4_hold_fmt", 64'(out_format), 64'(F_ADDR_ONLY));
    out_ready = 1'b1;
    drive_req(F_ADDR_ONLY, 32'h410, 1'b1);
    out_ready = 1'b0;
    chk("t4_no_drop", 64'(drop_cnt), 64'd1);
    chk("t4_new_head", 64'(out_addr), 64'h404);
    tick();
    chk("t4_hold_new_head", 64'(out_addr), 64'h404);
    out_ready = 1'b1;
    wait_empty("t4_drain");

    // 5: disable drains, re-enable during drain keeps contents
    out_ready = 1'b0;
    drive_req(F_BRANCH_FULL, 32'h500, 1'b1);
    drive_req(F_BRANCH_FULL, 32'h504, 1'b1);
    enable = 1'b0; req_valid = 1'b1; req_addr = 32'h5FF;
    tick();
    req_valid = 1'b0;
    chk("t5_drain_not_idle", 64'(idle), 64'd0);
    chk("t5_drain_head", 64'(out_addr), 64'h500);
    enable = 1'b1;
    tick();
    drive_req(F_BRANCH_FULL, 32'h508, 1'b1);
    enable = 1'b0; req_valid = 1'b1; req_addr = 32'h5EE;
    tick();
    out_ready = 1'b1;
    wait_empty("t5_drain");
    repeat (2) tick();
    req_valid = 1'b0;
    chk("t5_idle", 64'(idle), 64'd1);
    chk("t5_idle_empty", 64'(out_valid), 64'd0);
    chk("t5_idle_pending", 64'(pending), 64'd0);
    chk("t5_overflow_held", 64'(overflow), 64'd1);
    chk("t5_drop_cnt_held", 64'(drop_cnt), 64'd1);
    enable = 1'b1;
    tick();
    chk("t5_run_entry_overflow", 64'(overflow), 64'd0);
    chk("t5_run_entry_drop_cnt", 64'(drop_cnt), 64'd0);

    // 6: reset with entries queued
    out_ready = 1'b0;
    drive_req(F_BRANCH_DIFF, 32'h600, 1'b1);
    drive_req(F_BRANCH_DIFF, 32'h604, 1'b1);
    drive_req(F_BRANCH_DIFF, 32'h608, 1'b1);
    drive_req(F_BRANCH_DIFF, 32'h60C, 1'b1);
    drive_req(F_BRANCH_DIFF, 32'h610, 1'b0);
    chk("t6_drop_before_reset", 64'(drop_cnt), 64'd1);
    rst = 1'b1;
    tick();
    sb.delete();
    chk("t6_reset_valid", 64'(out_valid), 64'd0);
    chk("t6_reset_idle", 64'(idle), 64'd1);
    chk("t6_reset_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("t6_reset_overflow", 64'(overflow), 64'd0);
    chk("t6_reset_pending", 64'(pending), 64'd0);
    rst = 1'b0;
    tick();
    chk("t6_no_stale_entries", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
